// File: rtl/tsp_hex_display_if.sv
// Channel publication bus from the TSP solver core to the status display.
interface tsp_hex_display_if #(
  parameter int NUM_CH  = 4,
  parameter int VALUE_W = 20
);
  logic [NUM_CH*VALUE_W-1:0] ch_value;
  logic [NUM_CH-1:0]         ch_valid;

  modport master (output ch_value, output ch_valid);
  modport slave  (input  ch_value, input  ch_valid);
endinterface

// File: rtl/tsp_hex_display.sv
// Multi-channel status display: latches solver values, converts the selected one
// to BCD with a sequential double-dabble and drives active-low seven-segment digits.
module tsp_hex_display #(
  parameter int VALUE_W    = 20,
  parameter int NUM_DIGITS = 6,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  tsp_hex_display_if.slave        bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    hold,
  output logic [NUM_DIGITS*7-1:0] hex,
  output logic                    led_busy,
  output logic                    led_ovf
);

  localparam int BCD_W = (NUM_DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [NUM_DIGITS*7-1:0] HEX_RESET = {{(NUM_DIGITS-1){7'h7F}}, 7'h40};

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                    state, state_next;
  logic [VALUE_W-1:0]        latch [NUM_CH];
  logic [VALUE_W-1:0]        bin;
  logic [BCD_W-1:0]          bcd, bcd_adj;
  logic [CNT_W-1:0]          cnt;
  logic [SEL_W-1:0]          sel_q, sel_eff;
  logic                      dirty, dirty_set;
  logic [NUM_DIGITS*7-1:0]   hex_next;
  logic                      ovf_next;
  int                        top_digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Out-of-range selects fall back to channel 0.
  assign sel_eff   = (32'(sel) < 32'(NUM_CH)) ? sel : '0;
  assign dirty_set = bus.ch_valid[sel_eff] | (sel != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) latch[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (bus.ch_valid[c]) latch[c] <= bus.ch_value[c*VALUE_W +: VALUE_W];
    end
  end

  // A new request arriving in the same cycle as LOAD entry must not be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty <= 1'b0;
      sel_q <= '0;
    end else begin
      sel_q <= sel;
      if (dirty_set)
        dirty <= 1'b1;
      else if (state == IDLE && state_next == LOAD)
        dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dirty && !hold) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(VALUE_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d <= NUM_DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  // The guard digit catches values wider than the visible digits.
  always_comb begin
    ovf_next  = (bcd[BCD_W-1 -: 4] != 4'd0);
    top_digit = 0;
    hex_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) top_digit = i;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ovf_next)
        hex_next[7*i +: 7] = 7'h3F;
      else if (i > top_digit)
        hex_next[7*i +: 7] = 7'h7F;
      else
        hex_next[7*i +: 7] = seg7(bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      hex      <= HEX_RESET;
      led_ovf  <= 1'b0;
      led_busy <= 1'b0;
    end else begin
      led_busy <= (state_next != IDLE);
      case (state)
        LOAD: begin
          bin <= latch[sel_eff];
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          cnt        <= cnt + 1'b1;
        end
        DONE: begin
          hex     <= hex_next;
          led_ovf <= ovf_next;
        end
        default: ;
      endcase
    end
  end

endmodule
